// File: rtl/bus_pkg.sv
// Shared bus definitions for the master/slave interconnect.
//   ADDR_W/DATA_W/MASK_W : word address, data and byte-enable widths
//   bus_req_t            : request fields forwarded from the granted master
//   bus_rsp_t            : response delivered back to a master
//   addr_match()         : base/width address decode for a single slave
package bus_pkg;

    localparam int ADDR_W = 30;
    localparam int DATA_W = 32;
    localparam int MASK_W = 4;
    localparam int DW_W   = 5;   // width of one decode-width field

    typedef struct packed {
        logic              we;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] byte_mask;
    } bus_req_t;

    typedef struct packed {
        logic [DATA_W-1:0] data;
        logic              valid;
        logic              err;
    } bus_rsp_t;

    // Compare only the bits above the slave's window. A width of ADDR_W or
    // more shifts the one out entirely, so the mask becomes zero and the
    // slave owns the whole address space.
    function automatic logic addr_match(input logic [ADDR_W-1:0] addr,
                                        input logic [ADDR_W-1:0] base,
                                        input logic [DW_W-1:0]   width);
        logic [ADDR_W-1:0] mask;
        mask = ~((ADDR_W'(1) << width) - ADDR_W'(1));
        return ((addr ^ base) & mask) == '0;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter with grant freeze.
//   clk, rst : clock, asynchronous active-high reset
//   req      : per-requester request
//   hold     : current grant is stalled; keep it next cycle
//   advance  : current grant was accepted; move the round-robin pointer
//   gnt      : one-hot grant (zero when nobody requests)
module rr_arbiter #(
    parameter int N = 2
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [N-1:0] req,
    input  logic         hold,
    input  logic         advance,
    output logic [N-1:0] gnt
);

    localparam int IW = (N > 1) ? $clog2(N) : 1;

    logic [IW-1:0] last;
    logic [IW-1:0] gnt_idx;
    logic [N-1:0]  gnt_q;
    logic [N-1:0]  rr_gnt;
    logic          lock_q;

    // Walk from the farthest candidate back to last+1 so the closest
    // requester after 'last' is the final (winning) assignment.
    always_comb begin
        int idx;
        idx    = 0;
        rr_gnt = '0;
        for (int i = N; i >= 1; i--) begin
            idx = (int'(last) + i) % N;
            if (req[idx]) begin
                rr_gnt      = '0;
                rr_gnt[idx] = 1'b1;
            end
        end
    end

    // A stalled grant stays put as long as its owner keeps requesting.
    assign gnt = (lock_q && |(gnt_q & req)) ? gnt_q : rr_gnt;

    always_comb begin
        gnt_idx = '0;
        for (int i = 0; i < N; i++)
            if (gnt[i]) gnt_idx = IW'(i);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last   <= IW'(N - 1);
            gnt_q  <= '0;
            lock_q <= 1'b0;
        end else begin
            lock_q <= hold;
            gnt_q  <= gnt;
            if (advance) last <= gnt_idx;
        end
    end

endmodule

// File: rtl/bus_arb_intercon.sv
// N-master / M-slave shared-path interconnect.
//   clk, rst          : clock, asynchronous active-high reset
//   m_*_i             : packed per-master request fields
//   m_data_o/valid/err: per-master response, one cycle after acceptance
//   m_stall_o         : request present but not accepted this cycle
//   s_en_o            : one-hot select of the decoded slave
//   s_we/addr/data/byte_mask_o : granted master's request, shared by slaves
//   s_data/valid/stall_i      : packed per-slave responses and stall
module bus_arb_intercon
    import bus_pkg::*;
#(
    parameter int                          NUM_MASTERS = 2,
    parameter int                          NUM_SLAVES  = 2,
    parameter logic [NUM_SLAVES*ADDR_W-1:0] SLAVE_BASE = '0,
    parameter logic [NUM_SLAVES*DW_W-1:0]   SLAVE_WIDTH = {NUM_SLAVES{5'd4}}
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_MASTERS-1:0]        m_en_i,
    input  logic [NUM_MASTERS-1:0]        m_we_i,
    input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
    input  logic [NUM_MASTERS*DATA_W-1:0] m_data_i,
    input  logic [NUM_MASTERS*MASK_W-1:0] m_byte_mask_i,
    output logic [NUM_MASTERS*DATA_W-1:0] m_data_o,
    output logic [NUM_MASTERS-1:0]        m_valid_o,
    output logic [NUM_MASTERS-1:0]        m_stall_o,
    output logic [NUM_MASTERS-1:0]        m_err_o,
    output logic [NUM_SLAVES-1:0]         s_en_o,
    output logic                          s_we_o,
    output logic [ADDR_W-1:0]             s_addr_o,
    output logic [DATA_W-1:0]             s_data_o,
    output logic [MASK_W-1:0]             s_byte_mask_o,
    input  logic [NUM_SLAVES*DATA_W-1:0]  s_data_i,
    input  logic [NUM_SLAVES-1:0]         s_valid_i,
    input  logic [NUM_SLAVES-1:0]         s_stall_i
);

    localparam int MW = (NUM_MASTERS > 1) ? $clog2(NUM_MASTERS) : 1;
    localparam int SW = (NUM_SLAVES  > 1) ? $clog2(NUM_SLAVES)  : 1;

    logic [NUM_MASTERS-1:0] gnt;
    logic [NUM_MASTERS-1:0] accepted;
    logic [MW-1:0]          gidx;
    logic                   any_gnt;
    bus_req_t               req;
    logic                   hit;
    logic [SW-1:0]          sidx;
    logic                   sel_stall;
    logic                   accept;
    bus_rsp_t               rsp;

    logic                   rsp_vld;
    logic                   rsp_hit;
    logic [MW-1:0]          rsp_m;
    logic [SW-1:0]          rsp_s;

    rr_arbiter #(.N(NUM_MASTERS)) u_arb (
        .clk     (clk),
        .rst     (rst),
        .req     (m_en_i),
        .hold    (any_gnt & sel_stall),
        .advance (accept),
        .gnt     (gnt)
    );

    assign any_gnt = |gnt;

    // Request mux: zero when nobody is granted.
    always_comb begin
        req  = '0;
        gidx = '0;
        for (int m = 0; m < NUM_MASTERS; m++) begin
            if (gnt[m]) begin
                gidx          = MW'(m);
                req.we        = m_we_i[m];
                req.addr      = m_addr_i[m*ADDR_W +: ADDR_W];
                req.data      = m_data_i[m*DATA_W +: DATA_W];
                req.byte_mask = m_byte_mask_i[m*MASK_W +: MASK_W];
            end
        end
    end

    // Descending scan: the lowest matching slave is assigned last and wins.
    always_comb begin
        hit  = 1'b0;
        sidx = '0;
        for (int s = NUM_SLAVES - 1; s >= 0; s--) begin
            if (addr_match(req.addr, SLAVE_BASE[s*ADDR_W +: ADDR_W],
                           SLAVE_WIDTH[s*DW_W +: DW_W])) begin
                hit  = 1'b1;
                sidx = SW'(s);
            end
        end
    end

    // Unmapped requests never stall: they are answered by the error path.
    assign sel_stall = hit & s_stall_i[sidx];
    assign accept    = any_gnt & ~sel_stall;
    assign accepted  = accept ? gnt : '0;

    // Request-side outputs are forced low while reset is asserted.
    assign s_en_o        = (!rst && any_gnt && hit) ? (NUM_SLAVES'(1) << sidx) : '0;
    assign s_we_o        = !rst & req.we;
    assign s_addr_o      = rst ? '0 : req.addr;
    assign s_data_o      = rst ? '0 : req.data;
    assign s_byte_mask_o = rst ? '0 : req.byte_mask;
    assign m_stall_o     = rst ? '0 : (m_en_i & ~accepted);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_vld <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_m   <= '0;
            rsp_s   <= '0;
        end else if (accept) begin
            rsp_vld <= 1'b1;
            rsp_hit <= hit;
            rsp_m   <= gidx;
            rsp_s   <= sidx;
        end else begin
            rsp_vld <= 1'b0;
            rsp_hit <= 1'b0;
            rsp_m   <= '0;
            rsp_s   <= '0;
        end
    end

    // Mapped: pass the slave's response through. Unmapped: synthesize an error.
    always_comb begin
        if (rsp_hit)
            rsp = '{data: s_data_i[rsp_s*DATA_W +: DATA_W], valid: s_valid_i[rsp_s], err: 1'b0};
        else
            rsp = '{data: '0, valid: 1'b1, err: 1'b1};
    end

    always_comb begin
        m_valid_o = '0;
        m_err_o   = '0;
        m_data_o  = '0;
        if (rsp_vld && !rst) begin
            for (int m = 0; m < NUM_MASTERS; m++) begin
                if (MW'(m) == rsp_m) begin
                    m_valid_o[m]                  = rsp.valid;
                    m_err_o[m]                    = rsp.err;
                    m_data_o[m*DATA_W +: DATA_W]  = rsp.data;
                end
            end
        end
    end

endmodule

// File: tb/tb_bus_arb_intercon.sv
// Directed bench: two masters, slave0 at 0x12340000 (16 words), slave1 at
// 0x1bcd0000 (8 words). Slaves are simple memories answering one cycle
// after an unstalled select.
module tb_bus_arb_intercon;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  m_en_i, m_we_i, m_valid_o, m_stall_o, m_err_o;
    logic [59:0] m_addr_i;
    logic [63:0] m_data_i, m_data_o;
    logic [7:0]  m_byte_mask_i;
    logic [1:0]  s_en_o;
    logic        s_we_o;
    logic [29:0] s_addr_o;
    logic [31:0] s_data_o;
    logic [3:0]  s_byte_mask_o;
    logic [63:0] s_data_i;
    logic [1:0]  s_valid_i, s_stall_i;

    int vectors    = 0;
    int miscompares = 0;

    logic [31:0] mem [2][16];

    bus_arb_intercon #(
        .NUM_MASTERS (2),
        .NUM_SLAVES  (2),
        .SLAVE_BASE  ({30'h1bcd0000, 30'h12340000}),
        .SLAVE_WIDTH ({5'd3, 5'd4})
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .m_en_i        (m_en_i),
        .m_we_i        (m_we_i),
        .m_addr_i      (m_addr_i),
        .m_data_i      (m_data_i),
        .m_byte_mask_i (m_byte_mask_i),
        .m_data_o      (m_data_o),
        .m_valid_o     (m_valid_o),
        .m_stall_o     (m_stall_o),
        .m_err_o       (m_err_o),
        .s_en_o        (s_en_o),
        .s_we_o        (s_we_o),
        .s_addr_o      (s_addr_o),
        .s_data_o      (s_data_o),
        .s_byte_mask_o (s_byte_mask_o),
        .s_data_i      (s_data_i),
        .s_valid_i     (s_valid_i),
        .s_stall_i     (s_stall_i)
    );

    always #5 clk = ~clk;

    // Slave memories: respond next cycle to any unstalled select.
    always @(posedge clk) begin
        for (int s = 0; s < 2; s++) begin
            if (s_en_o[s] && !s_stall_i[s]) begin
                s_valid_i[s] <= 1'b1;
                if (s_we_o) begin
                    mem[s][s_addr_o[3:0]]  <= s_data_o;
                    s_data_i[s*32 +: 32]   <= 32'h0;
                end else begin
                    s_data_i[s*32 +: 32]   <= mem[s][s_addr_o[3:0]];
                end
            end else begin
                s_valid_i[s] <= 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic set_m(input int m, input logic en, input logic we,
                         input logic [29:0] a, input logic [31:0] d);
        m_en_i[m]             = en;
        m_we_i[m]             = we;
        m_addr_i[m*30 +: 30]  = a;
        m_data_i[m*32 +: 32]  = d;
        m_byte_mask_i[m*4 +: 4] = 4'hf;
    endtask

    // Move to the next falling edge, then let combinational paths settle.
    task automatic next_cyc();
        @(negedge clk);
    endtask

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[0][i] = 32'h0;
            mem[1][i] = 32'h51000000 + i;
        end
        s_data_i  = '0;
        s_valid_i = '0;
        s_stall_i = '0;
        m_en_i = '0; m_we_i = '0; m_addr_i = '0; m_data_i = '0; m_byte_mask_i = '0;
        rst = 1'b1;

        // Reset: requests present but every output held low.
        next_cyc();
        set_m(0, 1, 0, 30'h12340000, 32'h0);
        set_m(1, 1, 0, 30'h1bcd0000, 32'h0);
        #1;
        chk("rst_s_en",  s_en_o,    2'b00);
        chk("rst_stall", m_stall_o, 2'b00);
        chk("rst_addr",  s_addr_o,  30'h0);
        chk("rst_valid", m_valid_o, 2'b00);

        next_cyc();
        rst = 1'b0;
        set_m(0, 0, 0, 30'h0, 32'h0);
        set_m(1, 0, 0, 30'h0, 32'h0);

        // Single master write then read-back.
        next_cyc();
        set_m(0, 1, 1, 30'h12340000, 32'hdeadbeef);
        #1;
        chk("wr_s_en",  s_en_o,    2'b01);
        chk("wr_stall", m_stall_o, 2'b00);
        chk("wr_data",  s_data_o,  32'hdeadbeef);
        chk("wr_we",    s_we_o,    1'b1);
        next_cyc();
        set_m(0, 1, 0, 30'h12340000, 32'h0);
        #1;
        chk("rd_s_en",     s_en_o,    2'b01);
        chk("wr_rsp_vld",  m_valid_o, 2'b01);
        next_cyc();
        set_m(0, 0, 0, 30'h0, 32'h0);
        #1;
        chk("rd_rsp_vld",  m_valid_o, 2'b01);
        chk("rd_rsp_data", m_data_o,  {32'h0, 32'hdeadbeef});
        chk("idle_s_en",   s_en_o,    2'b00);

        // Both masters every cycle; last=0, so m1 goes first.
        next_cyc();
        set_m(0, 1, 0, 30'h12340000, 32'h0);
        set_m(1, 1, 0, 30'h1bcd0002, 32'h0);
        #1;
        chk("alt_a_s_en",  s_en_o,    2'b10);
        chk("alt_a_stall", m_stall_o, 2'b01);
        next_cyc(); #1;
        chk("alt_b_s_en",  s_en_o,    2'b01);
        chk("alt_b_stall", m_stall_o, 2'b10);
        chk("alt_b_vld",   m_valid_o, 2'b10);
        chk("alt_b_data",  m_data_o,  {32'h51000002, 32'h0});
        next_cyc(); #1;
        chk("alt_c_s_en",  s_en_o,    2'b10);
        chk("alt_c_vld",   m_valid_o, 2'b01);
        chk("alt_c_data",  m_data_o,  {32'h0, 32'hdeadbeef});
        next_cyc(); #1;
        chk("alt_d_s_en",  s_en_o,    2'b01);
        chk("alt_d_data",  m_data_o,  {32'h51000002, 32'h0});
        next_cyc();
        set_m(0, 0, 0, 30'h0, 32'h0);
        set_m(1, 0, 0, 30'h0, 32'h0);
        #1;
        chk("alt_e_vld",   m_valid_o, 2'b01);
        chk("alt_e_data",  m_data_o,  {32'h0, 32'hdeadbeef});

        // Unmapped read from m1.
        next_cyc();
        set_m(1, 1, 0, 30'h00000010, 32'h0);
        #1;
        chk("unm_s_en",  s_en_o,    2'b00);
        chk("unm_stall", m_stall_o, 2'b00);
        next_cyc();
        set_m(1, 0, 0, 30'h0, 32'h0);
        #1;
        chk("unm_vld",  m_valid_o, 2'b10);
        chk("unm_err",  m_err_o,   2'b10);
        chk("unm_data", m_data_o,  64'h0);

        // Slave1 stalls m1 for 3 cycles; m0 joins while m1 holds the grant.
        next_cyc();
        s_stall_i = 2'b10;
        set_m(1, 1, 0, 30'h1bcd0003, 32'h0);
        #1;
        chk("stl1_s_en",  s_en_o,    2'b10);
        chk("stl1_stall", m_stall_o, 2'b10);
        next_cyc();
        set_m(0, 1, 0, 30'h12340000, 32'h0);
        #1;
        chk("stl2_s_en",  s_en_o,    2'b10);
        chk("stl2_stall", m_stall_o, 2'b11);
        chk("stl2_addr",  s_addr_o,  30'h1bcd0003);
        next_cyc(); #1;
        chk("stl3_s_en",  s_en_o,    2'b10);
        chk("stl3_stall", m_stall_o, 2'b11);
        chk("stl3_vld",   m_valid_o, 2'b00);
        next_cyc();
        s_stall_i = 2'b00;
        #1;
        chk("stl4_s_en",  s_en_o,    2'b10);
        chk("stl4_stall", m_stall_o, 2'b01);
        chk("stl4_vld",   m_valid_o, 2'b00);
        next_cyc();
        set_m(1, 0, 0, 30'h0, 32'h0);
        #1;
        chk("stl5_s_en",  s_en_o,    2'b01);
        chk("stl5_stall", m_stall_o, 2'b00);
        chk("stl5_vld",   m_valid_o, 2'b10);
        chk("stl5_data",  m_data_o,  {32'h51000003, 32'h0});
        next_cyc();
        set_m(0, 0, 0, 30'h0, 32'h0);
        #1;
        chk("stl6_vld",   m_valid_o, 2'b01);
        chk("stl6_data",  m_data_o,  {32'h0, 32'hdeadbeef});

        // Decode boundary of slave1's 8-word window.
        next_cyc();
        set_m(0, 1, 0, 30'h1bcd0007, 32'h0);
        #1;
        chk("bnd_in_s_en", s_en_o, 2'b10);
        next_cyc();
        set_m(0, 1, 0, 30'h1bcd0008, 32'h0);
        #1;
        chk("bnd_out_s_en", s_en_o,    2'b00);
        chk("bnd_out_stall", m_stall_o, 2'b00);
        chk("bnd_in_vld",   m_valid_o, 2'b01);
        chk("bnd_in_data",  m_data_o,  {32'h0, 32'h51000007});
        next_cyc();
        set_m(0, 0, 0, 30'h0, 32'h0);
        #1;
        chk("bnd_out_vld", m_valid_o, 2'b01);
        chk("bnd_out_err", m_err_o,   2'b01);
        chk("bnd_out_data", m_data_o, 64'h0);

        // Reset right after an accepted read by m0.
        next_cyc();
        set_m(0, 1, 0, 30'h12340000, 32'h0);
        #1;
        chk("rmo_s_en", s_en_o, 2'b01);
        next_cyc();
        rst = 1'b1;
        set_m(1, 1, 0, 30'h1bcd0001, 32'h0);
        #1;
        chk("rmo_vld",   m_valid_o, 2'b00);
        chk("rmo_s_en0", s_en_o,    2'b00);
        chk("rmo_stall", m_stall_o, 2'b00);
        chk("rmo_err",   m_err_o,   2'b00);
        next_cyc();
        rst = 1'b0;
        #1;
        chk("post_rst_s_en",  s_en_o,    2'b01);
        chk("post_rst_stall", m_stall_o, 2'b10);
        chk("post_rst_vld",   m_valid_o, 2'b00);
        next_cyc();
        set_m(0, 0, 0, 30'h0, 32'h0);
        set_m(1, 0, 0, 30'h0, 32'h0);
        #1;
        chk("post_rst_rsp", m_valid_o, 2'b01);
        chk("post_rst_data", m_data_o, {32'h0, 32'hdeadbeef});

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
